// File: rtl/seripara_pkg.sv
// Shared constants and helpers for the seripara serial-to-parallel word converter.
package seripara_pkg;

    localparam bit MODE_MSB_FIRST = 1'b1;
    localparam bit MODE_LSB_FIRST = 1'b0;

    // Counter width for a given word width; never below one bit.
    function automatic int unsigned cw(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seripara_bitcnt.sv
// Bit counter for one word: counts enabled bits 0..WIDTH-1 and flags the last bit.
module seripara_bitcnt
    import seripara_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = cw(WIDTH)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr_i,
    input  logic          ena_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Explicit compare so non-power-of-2 widths wrap correctly.
    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ena_i) begin
            cnt_d = last_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seripara_word.sv
// Serial-in/parallel-out converter with word framing, capture register and valid/ready output.
module seripara_word
    import seripara_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = MODE_MSB_FIRST,
    localparam int unsigned CW = cw(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ena,
    input  logic             si,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             drdy,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q, q_d, nq;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovf_q, ovf_d;
    logic             last;
    logic             complete;
    logic             accept;

    seripara_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .res    (res),
        .clr_i  (clr),
        .ena_i  (ena),
        .cnt_o  (cnt),
        .last_o (last)
    );

    generate
        if (MSB_FIRST == MODE_MSB_FIRST) begin : g_msb
            assign nq = {q_q[WIDTH-2:0], si};
        end else begin : g_lsb
            assign nq = {si, q_q[WIDTH-1:1]};
        end
    endgenerate

    assign complete = ena && !clr && last;
    assign accept   = dvalid_q && drdy;

    always_comb begin
        q_d      = q_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovf_d    = ovf_q;
        if (clr) begin
            // Frame restart leaves the captured word and its handshake alone.
            q_d   = '0;
            ovf_d = 1'b0;
        end else begin
            if (ena) begin
                q_d = nq;
            end
            if (complete) begin
                if (!dvalid_q || drdy) begin
                    dout_d   = nq;
                    dvalid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (accept) begin
                dvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q_q      <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q      = q_q;
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign ovf    = ovf_q;

endmodule
